// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
// dsm_pkg : shared state encoding and helpers for the DSM capture sequencer
// Revision: 1.0
// ============================================================================
package dsm_pkg;

  localparam int MOD_BITS_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_FILL  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } dsm_state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_out_fifo.sv
`default_nettype none
// ============================================================================
// dsm_out_fifo : 2-entry valid/ready register FIFO with synchronous flush
// Revision: 1.0
// ============================================================================
module dsm_out_fifo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             w_pop;

  always_comb begin
    w_pop   = (count_q != 2'd0) && i_ready;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (i_valid) begin
            head_d  = i_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (w_pop && i_valid) begin
            head_d = i_data;
          end else if (w_pop) begin
            count_d = 2'd0;
          end else if (i_valid) begin
            tail_d  = i_data;
            count_d = 2'd2;
          end
        end
        default: begin
          // Full: the tail slides into the head on every accept.
          if (w_pop) begin
            head_d = tail_q;
            if (i_valid) tail_d = i_data;
            else         count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = head_q;
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/dsm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// dsm_capture_ctrl : arms, captures and plays back DSM samples through a buffer
// Revision: 1.0
// ============================================================================
module dsm_capture_ctrl
  import dsm_pkg::*;
#(
  parameter int MOD_BITS = MOD_BITS_DEFAULT,
  parameter int SAMPLES  = 16,
  localparam int PTR_W   = clog2(SAMPLES)
) (
  input  logic                internal_clk,
  input  logic                internal_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                trigger,
  input  logic                loop,
  input  logic [PTR_W:0]      length,
  input  logic                sample_valid,
  input  logic [MOD_BITS-1:0] sample_bits,
  output logic                buf_we,
  output logic [PTR_W-1:0]    buf_waddr,
  output logic [MOD_BITS-1:0] buf_wdata,
  output logic                buf_re,
  output logic [PTR_W-1:0]    buf_raddr,
  input  logic [MOD_BITS-1:0] buf_rdata,
  output logic                out_valid,
  output logic [MOD_BITS-1:0] out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state
);

  localparam int             LEN_W      = PTR_W + 1;
  localparam logic [LEN_W-1:0] C_FULL_LEN = LEN_W'(SAMPLES);

  dsm_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rd_stop_q, rd_stop_d;
  logic             inflight_q, inflight_d;

  logic             w_write_window;
  logic             w_we;
  logic             w_issue;
  logic             w_pop;
  logic [2:0]       w_occ;
  logic             w_fifo_valid;
  logic [1:0]       w_fifo_count;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    rd_stop_d  = rd_stop_q;
    inflight_d = 1'b0;
    w_issue    = 1'b0;

    w_write_window = (state_q == ST_FILL) || ((state_q == ST_ARMED) && trigger);
    w_we           = !abort && sample_valid && w_write_window;
    w_pop          = w_fifo_valid && out_ready;
    // Slots already promised to the output FIFO after this cycle's accept.
    w_occ          = {1'b0, w_fifo_count} + {2'b00, inflight_q} - {2'b00, w_pop};

    if (abort) begin
      state_d   = ST_IDLE;
      wr_cnt_d  = '0;
      rd_ptr_d  = '0;
      rd_stop_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_ARMED;
            len_d     = ((length == '0) || (length > C_FULL_LEN)) ? C_FULL_LEN : length;
            wr_cnt_d  = '0;
            rd_ptr_d  = '0;
            rd_stop_d = 1'b0;
          end
        end
        ST_ARMED, ST_FILL: begin
          if (state_q == ST_ARMED && trigger) state_d = ST_FILL;
          if (w_we) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == len_q - 1'b1) begin
              state_d  = ST_PLAY;
              rd_ptr_d = '0;
            end
          end
        end
        ST_PLAY: begin
          if (!rd_stop_q && (w_occ < 3'd2)) begin
            w_issue    = 1'b1;
            inflight_d = 1'b1;
            if (rd_ptr_q == len_q - 1'b1) begin
              if (loop) rd_ptr_d  = '0;
              else      rd_stop_d = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end
          if (rd_stop_q && (w_fifo_count == 2'd0) && !inflight_q) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge internal_clk or negedge internal_rst_n) begin
    if (!internal_rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      rd_stop_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_stop_q  <= rd_stop_d;
      inflight_q <= inflight_d;
    end
  end

  dsm_out_fifo #(
    .WIDTH (MOD_BITS)
  ) u_out_fifo (
    .clk     (internal_clk),
    .rst_n   (internal_rst_n),
    .i_flush (abort),
    .i_valid (inflight_q),
    .i_data  (buf_rdata),
    .i_ready (out_ready),
    .o_valid (w_fifo_valid),
    .o_data  (out_data),
    .o_count (w_fifo_count)
  );

  assign buf_we    = w_we;
  assign buf_waddr = wr_cnt_q[PTR_W-1:0];
  assign buf_wdata = sample_bits;
  assign buf_re    = w_issue;
  assign buf_raddr = rd_ptr_q[PTR_W-1:0];
  assign out_valid = w_fifo_valid;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign state     = state_q;

endmodule
`default_nettype wire

// File: doc/dsm_capture_ctrl.md
Name: dsm_capture_ctrl

Overview:
Sequencer for the DSM sample buffer. It arms a capture, waits for a trigger, and fills a single-port-per-side buffer RAM with LENGTH modulator samples. It then plays the samples out on a valid/ready stream, once or looping. It sits between the modulator sample strobe and the downstream consumer, and owns both buffer address pointers.

Parameters:
MOD_BITS, 4, width of one modulator sample
SAMPLES, 16, buffer depth in samples (power of two, 2..65536)
PTR_W, clog2(SAMPLES), buffer address width (derived localparam)

Ports:
internal_clk  in  1  block clock
internal_rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle pulse: arm a capture
abort  in  1  return to IDLE, flush playback
trigger  in  1  capture begins on this pulse while ARMED
loop  in  1  playback wraps to address 0 instead of finishing; sampled continuously
length  in  PTR_W+1  samples to capture; latched on accepted start
sample_valid  in  1  modulator sample strobe
sample_bits  in  MOD_BITS  modulator sample
buf_we  out  1  buffer write enable
buf_waddr  out  PTR_W  buffer write address
buf_wdata  out  MOD_BITS  buffer write data
buf_re  out  1  buffer read enable
buf_raddr  out  PTR_W  buffer read address
buf_rdata  in  MOD_BITS  read data, valid exactly 1 cycle after buf_re
out_valid  out  1  playback sample valid
out_data  out  MOD_BITS  playback sample
out_ready  in  1  consumer accept
busy  out  1  state != IDLE and state != DONE
done  out  1  high in DONE
state  out  3  IDLE=0, ARMED=1, FILL=2, PLAY=3, DONE=4

Behaviour:
- Reset (async assert, synchronous deassert handled externally): state=IDLE, all pointers and counters 0, buf_we=buf_re=0, out_valid=0, out_data=0, busy=0, done=0.
- Length latch: len_q = length on accepted start. length==0 or length>SAMPLES is stored as SAMPLES.
- IDLE/DONE + start -> ARMED. start is ignored in ARMED, FILL and PLAY.
- ARMED + trigger -> FILL. If sample_valid is high in the trigger cycle, that sample is written as sample 0.
- FILL: each sample_valid gives buf_we=1 in the same cycle, combinational from sample_valid and state; buf_waddr=wr_cnt, buf_wdata=sample_bits, then wr_cnt+1.
  - When the write with wr_cnt==len_q-1 occurs: go to PLAY, rd_ptr=0.
  - sample_valid outside FILL (or the ARMED trigger cycle) is dropped; no write.
- PLAY, read side:
  - 2-entry output FIFO plus in-flight flag.
  - Issue buf_re when (fifo_count + inflight - pop) < 2 and reads remain.
  - Data enters the FIFO the cycle after buf_re.
  - Sustains 1 sample/cycle with out_ready held high. First out_valid is 2 cycles after entering PLAY.
- PLAY, pointer advance: rd_ptr increments per issued read.
  - At rd_ptr==len_q-1: if loop, wrap to 0; else stop issuing.
- PLAY -> DONE when loop=0, all len_q reads issued, FIFO empty and nothing in flight.
- Output stream: out_data/out_valid come from the FIFO head. out_data holds while out_valid && !out_ready. Never drops or duplicates a sample.
- Loop deasserted mid-PLAY: finish at the next len_q-1 boundary.
- abort (priority over every other input, any state): next cycle state=IDLE, FIFO flushed, out_valid=0, in-flight read discarded, counters 0. Buffer contents are untouched.
- Pointers: wr_cnt and rd_ptr are PTR_W+1 bits; addresses are their low PTR_W bits. No write ever occurs at address >= len_q.
- Simultaneous start+abort: abort wins, state stays IDLE.

Decomposition:
- Shared package dsm_pkg: state encoding constants (IDLE..DONE), the CLOG2 helper/function, MOD_BITS default.
- One sub-module is natural: dsm_out_fifo, a 2-entry valid/ready register FIFO with a flush input, parameterised by width.

Test Plan:
- Basic capture: start, length=4, trigger, samples 1,2,3,4 on consecutive cycles, out_ready=1 -> buf_we at addrs 0..3, out_data 1,2,3,4 back-to-back, done=1, state=4.
- Backpressure: length=3, data A,B,C, out_ready toggles 1,0,0,1,0,1 -> out_data stable while stalled, sequence A,B,C exactly once.
- Loop: length=2, data 5,9, loop=1 for 6 accepts -> 5,9,5,9,5,9; then loop=0 -> stream ends after next 9, DONE.
- Length edge cases: length=0 and length=20 with SAMPLES=16 -> 16 writes at addrs 0..15; pre-trigger sample_valid pulses -> no buf_we.
- Abort mid-FILL after 2 writes, and mid-PLAY with out_valid=1 -> state=0 next cycle, out_valid=0; new start/trigger captures cleanly from addr 0.
- Async reset asserted mid-PLAY, off clock edge -> all outputs at reset values immediately; start+abort same cycle -> remains IDLE.
